// File: rtl/r_cpu_seq_ctrl_pkg.sv
// Shared definitions for the multi-cycle R-type control FSM:
// state encoding, ALU operation codes, func codes, opcode and trap causes.
package r_cpu_seq_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned CAUSE_W  = 2;
    localparam int unsigned STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b101;
    localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b110;
    localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b111;

    localparam logic [FUNC_W-1:0] FUNC_AND  = 6'h24;
    localparam logic [FUNC_W-1:0] FUNC_OR   = 6'h25;
    localparam logic [FUNC_W-1:0] FUNC_XOR  = 6'h26;
    localparam logic [FUNC_W-1:0] FUNC_NOR  = 6'h27;
    localparam logic [FUNC_W-1:0] FUNC_ADD  = 6'h20;
    localparam logic [FUNC_W-1:0] FUNC_SUB  = 6'h22;
    localparam logic [FUNC_W-1:0] FUNC_SLT  = 6'h2A;
    localparam logic [FUNC_W-1:0] FUNC_SLLV = 6'h04;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;

    localparam logic [CAUSE_W-1:0] TRAP_NONE    = 2'b00;
    localparam logic [CAUSE_W-1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [CAUSE_W-1:0] TRAP_OVF     = 2'b10;

    // Result of decoding the func field.
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                legal;
        logic                is_signed_arith;
    } func_dec_t;

endpackage

// File: rtl/r_cpu_seq_ctrl_if.sv
// Control/datapath bundle between the sequencer and the R-type datapath.
//   OP, func   : instruction register fields (to controller)
//   OF         : ALU signed-overflow flag (to controller)
//   PC_Write, IR_Write, Write_Reg : datapath write enables (from controller)
//   ALU_OP     : ALU operation select (from controller)
interface r_cpu_seq_ctrl_if;
    import r_cpu_seq_ctrl_pkg::*;

    logic [OP_W-1:0]     OP;
    logic [FUNC_W-1:0]   func;
    logic                OF;
    logic                PC_Write;
    logic                IR_Write;
    logic                Write_Reg;
    logic [ALU_OP_W-1:0] ALU_OP;

    // Controller side.
    modport master (
        input  OP, func, OF,
        output PC_Write, IR_Write, Write_Reg, ALU_OP
    );

    // Datapath side.
    modport slave (
        output OP, func, OF,
        input  PC_Write, IR_Write, Write_Reg, ALU_OP
    );
endinterface

// File: rtl/r_func_decode.sv
// Combinational R-type func decoder: func -> {ALU op, legal, signed-arith}.
//   i_func : instruction func field
//   o_dec  : decoded ALU op, legality flag, add/sub flag
module r_func_decode
    import r_cpu_seq_ctrl_pkg::*;
(
    input  logic [FUNC_W-1:0] i_func,
    output func_dec_t         o_dec
);

    always_comb begin
        o_dec                 = '0;
        o_dec.legal           = 1'b1;
        case (i_func)
            FUNC_AND:  o_dec.alu_op = ALU_AND;
            FUNC_OR:   o_dec.alu_op = ALU_OR;
            FUNC_XOR:  o_dec.alu_op = ALU_XOR;
            FUNC_NOR:  o_dec.alu_op = ALU_NOR;
            FUNC_ADD: begin
                o_dec.alu_op          = ALU_ADD;
                o_dec.is_signed_arith = 1'b1;
            end
            FUNC_SUB: begin
                o_dec.alu_op          = ALU_SUB;
                o_dec.is_signed_arith = 1'b1;
            end
            FUNC_SLT:  o_dec.alu_op = ALU_SLT;
            FUNC_SLLV: o_dec.alu_op = ALU_SLL;
            default:   o_dec.legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/r_cpu_seq_ctrl.sv
// Multi-cycle control FSM (IDLE/FETCH/DECODE/EXEC/WB/TRAP) for the R-type datapath.
//   CLK, RST   : clock, synchronous active-low reset
//   run, step  : free-run level, single-step request (rising edge)
//   bus        : OP/func/OF in, PC_Write/IR_Write/Write_Reg/ALU_OP out
//   busy       : FSM in FETCH..WB
//   trap       : sticky trap flag, trap_cause 00 none / 01 illegal / 10 overflow
//   inst_cnt   : retired-instruction counter (wraps)
module r_cpu_seq_ctrl
    import r_cpu_seq_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter bit          TRAP_ON_OF = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                run,
    input  logic                step,
    r_cpu_seq_ctrl_if.master    bus,
    output logic                busy,
    output logic                trap,
    output logic [CAUSE_W-1:0]  trap_cause,
    output logic [CNT_W-1:0]    inst_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_step_d;
    logic [ALU_OP_W-1:0] r_alu_op;
    logic [ALU_OP_W-1:0] w_alu_op_nxt;
    logic                r_is_arith;
    logic                w_is_arith_nxt;
    logic [CAUSE_W-1:0]  r_trap_cause;
    logic [CAUSE_W-1:0]  w_cause_nxt;
    logic [CNT_W-1:0]    r_inst_cnt;
    logic                w_retire;
    logic                r_pc_write;
    logic                r_ir_write;
    logic                r_write_reg;
    logic                r_busy;
    logic                r_trap;
    logic                w_step_edge;
    func_dec_t           w_dec;

    r_func_decode u_func_decode (
        .i_func (bus.func),
        .o_dec  (w_dec)
    );

    assign w_step_edge = step & ~r_step_d;

    // Next-state, ALU op load, trap cause and retire decisions.
    always_comb begin
        w_next_state   = r_state;
        w_alu_op_nxt   = r_alu_op;
        w_is_arith_nxt = r_is_arith;
        w_cause_nxt    = r_trap_cause;
        w_retire       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run || w_step_edge) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: w_next_state = ST_DECODE;
            ST_DECODE: begin
                if ((bus.OP != OP_RTYPE) || !w_dec.legal) begin
                    w_cause_nxt  = TRAP_ILLEGAL;
                    w_next_state = ST_TRAP;
                end else begin
                    w_alu_op_nxt   = w_dec.alu_op;
                    w_is_arith_nxt = w_dec.is_signed_arith;
                    w_next_state   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (TRAP_ON_OF && r_is_arith && bus.OF) begin
                    w_cause_nxt  = TRAP_OVF;
                    w_next_state = ST_TRAP;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_WB: begin
                w_retire     = 1'b1;
                w_next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_TRAP: w_next_state = ST_TRAP;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State and registered Moore outputs (decoded from the next state).
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_step_d     <= 1'b0;
            r_alu_op     <= ALU_AND;
            r_is_arith   <= 1'b0;
            r_trap_cause <= TRAP_NONE;
            r_inst_cnt   <= '0;
            r_pc_write   <= 1'b0;
            r_ir_write   <= 1'b0;
            r_write_reg  <= 1'b0;
            r_busy       <= 1'b0;
            r_trap       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_step_d     <= step;
            r_alu_op     <= w_alu_op_nxt;
            r_is_arith   <= w_is_arith_nxt;
            r_trap_cause <= w_cause_nxt;
            r_inst_cnt   <= w_retire ? r_inst_cnt + CNT_W'(1) : r_inst_cnt;
            r_pc_write   <= (w_next_state == ST_FETCH);
            r_ir_write   <= (w_next_state == ST_FETCH);
            r_write_reg  <= (w_next_state == ST_WB);
            r_busy       <= (w_next_state == ST_FETCH) || (w_next_state == ST_DECODE) ||
                            (w_next_state == ST_EXEC)  || (w_next_state == ST_WB);
            r_trap       <= (w_next_state == ST_TRAP);
        end
    end

    // Enables are masked by RST so a reset landing mid-instruction never commits a write.
    assign bus.PC_Write  = r_pc_write  & RST;
    assign bus.IR_Write  = r_ir_write  & RST;
    assign bus.Write_Reg = r_write_reg & RST;
    assign bus.ALU_OP    = r_alu_op;
    assign busy          = r_busy;
    assign trap          = r_trap;
    assign trap_cause    = r_trap_cause;
    assign inst_cnt      = r_inst_cnt;

endmodule

// File: doc/r_cpu_seq_ctrl.md
Name: r_cpu_seq_ctrl

Overview:
- Multi-cycle control FSM for the R-type CPU datapath: PC/instruction fetch, register file (2R/1W), 3-bit-op ALU.
- Replaces single-cycle combinational control: each instruction runs FETCH -> DECODE -> EXEC -> WB, with the datapath write enables asserted in the correct cycle.
- Supports free-run and single-step operation; traps on illegal instructions and on signed overflow.
- Sits between the instruction register fields (OP, func) and the PC, IR, register-file and ALU controls.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- TRAP_ON_OF, 1, 1 = signed overflow on add/sub traps and suppresses writeback; 0 = overflow ignored.

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  synchronous reset, active-low.
- run  in  1  level; 1 = continuous execution.
- step  in  1  single-step request; rising edge detected internally.
- OP  in  6  Inst_code[31:26].
- func  in  6  Inst_code[5:0].
- OF  in  1  ALU signed-overflow flag, valid during EXEC.
- PC_Write  out  1  PC advances (PC+4) at end of cycle.
- IR_Write  out  1  instruction register loads at end of cycle.
- Write_Reg  out  1  register file writes rd with ALU F at end of cycle.
- ALU_OP  out  3  registered ALU operation.
- busy  out  1  state not in IDLE/TRAP.
- trap  out  1  sticky trap indicator.
- trap_cause  out  2  00 none, 01 illegal, 10 overflow.
- inst_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (RST==0 at a CLK edge):
  - state = IDLE; ALU_OP = 3'b000.
  - PC_Write, IR_Write, Write_Reg, busy, trap = 0; trap_cause = 00; inst_cnt = 0.
  - step edge-detect register = 0.
  - Reset overrides everything, including mid-instruction: no write enable is asserted in the reset cycle.
- States: IDLE, FETCH, DECODE, EXEC, WB, TRAP. Enables are Moore outputs decoded from the state register.
- IDLE:
  - Go to FETCH if run==1 or a step edge is seen (step==1, previous step==0).
  - Step edges seen in any other state are discarded, not queued.
- FETCH: PC_Write=1, IR_Write=1 for exactly one cycle; then DECODE.
- DECODE: OP and func are valid here.
  - If OP!=6'b000000 or func not in the table below: trap_cause=01, go to TRAP.
  - Otherwise load ALU_OP from the table and go to EXEC.
- ALU_OP table (func -> ALU_OP):
  - 0x24 and -> 000
  - 0x25 or -> 001
  - 0x26 xor -> 010
  - 0x27 nor -> 011
  - 0x20 add -> 100
  - 0x22 sub -> 101
  - 0x2A slt -> 110
  - 0x04 sllv -> 111
- EXEC:
  - ALU_OP held; A/B settle.
  - If TRAP_ON_OF==1, ALU_OP is 100 or 101, and OF==1: trap_cause=10, go to TRAP.
  - Otherwise go to WB.
- WB:
  - Write_Reg=1 for exactly one cycle; inst_cnt increments (wraps at 2^CNT_W-1 -> 0).
  - Then FETCH if run==1, else IDLE.
- TRAP: all enables 0; trap=1; ALU_OP held. Exit only via reset; run and step are ignored.
- Timing:
  - Latency is 4 cycles per instruction; in free run, back-to-back instructions give PC_Write every 4th cycle.
  - At most one of PC_Write, IR_Write, Write_Reg is asserted, except FETCH, where PC_Write and IR_Write are both 1.
- run dropped mid-instruction: the current instruction completes, then the FSM returns to IDLE.
- busy=1 in FETCH, DECODE, EXEC and WB.

Decomposition:
- Shared package:
  - State encoding localparams.
  - ALU_OP codes (ALU_AND..ALU_SLL).
  - func codes (FUNC_ADD etc.).
  - OP_RTYPE = 6'b000000.
  - Trap-cause codes.
- One natural sub-module, r_func_decode: combinational func -> {ALU_OP, legal, is_signed_arith}. Reused by any future single-cycle controller.

Test Plan:
- Reset: hold RST=0 two cycles with run=1 -> all outputs 0, state IDLE; release -> PC_Write=IR_Write=1 on first cycle after release.
- Free run of add (OP=0, func=0x20), OF=0 -> ALU_OP=100 from EXEC; Write_Reg=1 in cycle 4; PC_Write in cycles 1, 5, 9; inst_cnt=3 after 12 cycles.
- Single step, run=0: one step pulse -> exactly one FETCH..WB sequence, inst_cnt=1, then IDLE. A second pulse during EXEC is ignored; a pulse held high 10 cycles counts once.
- Overflow: func=0x22 with OF=1 in EXEC -> no Write_Reg; trap=1, trap_cause=10; inst_cnt unchanged; run/step have no effect until reset. Repeat with TRAP_ON_OF=0 -> Write_Reg asserted.
- Illegal: OP=6'b100011 -> trap_cause=01. OP=0 with func=0x3F -> trap_cause=01. No Write_Reg in either case.
- Mid-op reset and wrap: assert RST=0 during WB -> Write_Reg=0 that cycle, everything reset. With CNT_W=4, run 16 instructions -> inst_cnt wraps to 0.
